dp_ram_stream_reader: RTL and testbench
=======================================

# dp_ram_stream_reader

Read-side streaming engine for `simple_dp_ram`. It drives the RAM's read port (`a2`/`rd2`, data back on `spo2`) to fetch a run of consecutive words starting at a programmable base address. The words are presented on a valid/ready stream with a last-beat marker. It sits in the `clk2` domain between the dual-port RAM and a consumer such as a scanout, UART or DMA sink, while another master fills the RAM through the write port.

## Interface
- `WIDTH`, 32, data word width; must match the RAM's `WIDTH`.
- `DEPTH`, 10, address bits; must match the RAM's `DEPTH`. The RAM holds 2**DEPTH words.

- `clk`  in  1  clock; connect the same net to the RAM's `clk2`.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transfer; accepted only in IDLE.
- `base`  in  DEPTH  first word address; sampled when `start` is accepted.
- `len`  in  DEPTH+1  word count, 0..2**DEPTH; sampled when `start` is accepted.
- `ram_a`  out  DEPTH  connects to the RAM's `a2`.
- `ram_rd`  out  1  connects to the RAM's `rd2`; high when a read is issued this cycle.
- `ram_q`  in  WIDTH  connects to the RAM's `spo2`.
- `m_data`  out  WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from the consumer.
- `m_last`  out  1  marks the final word of a pass; qualified by `m_valid`.
- `busy`  out  1  high from the edge after `start` is accepted until the final beat completes.
- `done`  out  1  one-cycle pulse after the final beat.

## Operation
- **States:** IDLE, RUN.
- **IDLE → RUN:** `start`=1 at an edge. Latch `base` into the address counter and `len` into the issue and beat counters.
- **Zero-length start:** if the latched `len`=0, stay in IDLE, issue no reads, and pulse `done` in the next cycle.
- **Ignored starts:** `start` in RUN is ignored.
- **Read issue (RUN):** `ram_rd`=1 when issue count > 0 and buffer occupancy + in-flight < 3.
  - Each issue increments `ram_a` modulo 2**DEPTH, so the address wraps from 2**DEPTH-1 to 0.
  - Each issue decrements the issue count.
- **Capture:** `spo2` updates every `clk2` edge regardless of `rd2`. `ram_q` is therefore written into the buffer only in the cycle exactly one edge after an issue, tracked by an `inflight` flag.
- **Output buffer:** 3-entry FIFO. `m_valid` = FIFO not empty; `m_data` = FIFO head.
  - A beat completes when `m_valid` and `m_ready` are both high; the FIFO pops and the beat counter decrements.
  - `m_last`=1 when the beat counter equals 1.
  - There is no combinational path from `m_ready` to `ram_rd`.
- **Completion:** when the final beat completes, go to IDLE. `busy` falls and `done` pulses in the following cycle.
- **Consumer stall:** `m_valid`/`m_data` stay stable while `m_ready`=0. Issue stops once occupancy + in-flight = 3, so the FIFO never overflows.
- **Reset:** `rst` in any state returns to IDLE, clears the FIFO and the in-flight flag, and discards data.

## Timing
- **Reset values:** `ram_a`=0, `ram_rd`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `done`=0.
- **Start:** accepted at edge E0. In the cycle after E0, `busy`=1, `ram_rd`=1 and `ram_a`=`base`.
- **First word:** the RAM samples at E1, the buffer captures at E2, and `m_valid`=1 after E2. Start-to-first-valid latency is 2 cycles.
- **Throughput:** 1 word per cycle sustained while `m_ready`=1; `len` words take `len`+2 cycles from start to the last beat.
- **Done:** the final beat completes at edge En; after En, `busy`=0 and `done`=1 for one cycle.
- **Restart:** a new `start` is accepted on the edge where `done`=1.

## Configuration
- `DP_STREAM_READER_LOOP_EN` defined:
  - Adds input `loop` (1 bit).
  - When the last read of a pass is issued with `loop`=1, the address counter reloads the latched `base`, the issue count reloads `len`, and reading continues with no gap.
  - `m_last` still marks the final word of each pass.
  - `done` pulses only after a pass whose last issue saw `loop`=0.
- Undefined: the `loop` port is absent and every transfer is a single pass.

## Test plan
- `base`=0x010, `len`=4, RAM[0x010..0x013]=A0..A3, `m_ready`=1 → `m_valid` 2 cycles after start; beats A0,A1,A2,A3 on consecutive cycles; `m_last` only with A3; `done` pulses 1 cycle later.
- `base`=0x3FE, `len`=4, `DEPTH`=10 → reads 0x3FE, 0x3FF, 0x000, 0x001 in that order.
- `len`=8 with `m_ready` toggled 1,0,0,1,0,1... → all 8 words delivered in order with no loss or duplication; `m_data` stable during stalls; at most 3 reads outstanding.
- `len`=0 → no `ram_rd`; `busy` stays 0; `done` pulses once.
- `rst` asserted mid-transfer after 3 beats, then a new start with `base`=0x020, `len`=2 → the new run delivers only RAM[0x020], RAM[0x021]; no stale words.
- `DP_STREAM_READER_LOOP_EN` defined, `len`=3, `loop`=1 for 2 passes then 0 → 9 contiguous beats; `m_last` on beats 3, 6, 9; a single `done`.

Source files
------------

// File: rtl/dp_ram_stream_reader.sv
// Streams a run of consecutive words out of simple_dp_ram's read port as a valid/ready stream.
// Optional continuous re-reading of the run is enabled with DP_STREAM_READER_LOOP_EN.
module dp_ram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DEPTH-1:0] base,
    input  logic [DEPTH:0]   len,
`ifdef DP_STREAM_READER_LOOP_EN
    input  logic             loop,
`endif
    output logic [DEPTH-1:0] ram_a,
    output logic             ram_rd,
    input  logic [WIDTH-1:0] ram_q,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DEPTH-1:0] A_ONE = 1;
    localparam logic [DEPTH:0]   C_ONE = 1;

    state_t           state;
    logic [DEPTH:0]   issue_cnt;
    logic [DEPTH:0]   beat_cnt;
    logic             inflight;
    logic [WIDTH-1:0] fifo [3];
    logic [1:0]       wr_ptr, rd_ptr, occ;
    logic             push, pop, last_issue, last_beat;
`ifdef DP_STREAM_READER_LOOP_EN
    logic [DEPTH-1:0] base_q;
    logic [DEPTH:0]   len_q;
    logic [1:0]       passes;
`endif

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue decision uses only registered occupancy, keeping m_ready out of the read path.
    assign ram_rd     = (state == RUN) && (issue_cnt != '0) &&
                        (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
    assign push       = inflight;
    assign m_valid    = (occ != 2'd0);
    assign pop        = m_valid && m_ready;
    assign m_data     = m_valid ? fifo[rd_ptr] : '0;
    assign m_last     = m_valid && (beat_cnt == C_ONE);
    assign busy       = (state == RUN);
    assign last_issue = ram_rd && (issue_cnt == C_ONE);
    assign last_beat  = pop && (beat_cnt == C_ONE);

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= ram_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_a     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occ       <= 2'd0;
            done      <= 1'b0;
`ifdef DP_STREAM_READER_LOOP_EN
            base_q    <= '0;
            len_q     <= '0;
            passes    <= 2'd0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= ram_rd;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start) begin
                        ram_a     <= base;
                        issue_cnt <= len;
                        beat_cnt  <= len;
`ifdef DP_STREAM_READER_LOOP_EN
                        base_q    <= base;
                        len_q     <= len;
                        passes    <= 2'd0;
`endif
                        if (len == '0)
                            done <= 1'b1;
                        else
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (ram_rd) begin
`ifdef DP_STREAM_READER_LOOP_EN
                        if (last_issue && loop) begin
                            ram_a     <= base_q;
                            issue_cnt <= len_q;
                        end else
`endif
                        begin
                            ram_a     <= ram_a + A_ONE;
                            issue_cnt <= issue_cnt - C_ONE;
                        end
                    end
                    if (pop) begin
                        beat_cnt <= beat_cnt - C_ONE;
                        if (last_beat) begin
`ifdef DP_STREAM_READER_LOOP_EN
                            // Passes already issued behind this one keep the run going.
                            if (passes != 2'd0)
                                beat_cnt <= len_q;
                            else
`endif
                            begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
`ifdef DP_STREAM_READER_LOOP_EN
                    passes <= passes + {1'b0, (last_issue && loop)}
                                     - {1'b0, (last_beat && (passes != 2'd0))};
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Bench for dp_ram_stream_reader: behavioural RAM plus an ordered-word reference of each transfer.
module tb_dp_ram_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int D     = 1 << DEPTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [DEPTH-1:0] base;
    logic [DEPTH:0]   len;
`ifdef DP_STREAM_READER_LOOP_EN
    logic             loop;
`endif
    logic [DEPTH-1:0] ram_a;
    logic             ram_rd;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] mem [D];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Read port of the RAM: output register refreshes every edge.
    always @(posedge clk) ram_q <= mem[ram_a];

    dp_ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
`ifdef DP_STREAM_READER_LOOP_EN
        .loop(loop),
`endif
        .ram_a(ram_a), .ram_rd(ram_rd), .ram_q(ram_q),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ram_rd"}, ram_rd, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ram_a"}, ram_a, 0);
    endtask

    // Runs one transfer from a negedge. mode: 0 ready always, 1 fixed stall pattern, 2 random.
    // passes > 1 requests looping (only meaningful with the loop feature). stop_at >= 0 returns early.
    task automatic run_xfer(input int b, input int n, input int mode, input int passes, input int stop_at);
        int issued, beats, cyc, total, ph;
        logic [WIDTH-1:0] pdata;
        logic pstall;
        total  = n * passes;
        issued = 0;
        beats  = 0;
        pstall = 1'b0;
        pdata  = '0;
        start  = 1'b1;
        base   = b[DEPTH-1:0];
        len    = n[DEPTH:0];
        m_ready = 1'b0;
`ifdef DP_STREAM_READER_LOOP_EN
        loop = (passes > 1);
`endif
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (n == 0) begin
            chk("zl_done", done, 1);
            chk("zl_busy", busy, 0);
            chk("zl_ram_rd", ram_rd, 0);
            @(negedge clk);
            chk("zl_done_clear", done, 0);
            chk("zl_busy2", busy, 0);
            chk("zl_ram_rd2", ram_rd, 0);
            return;
        end
        chk("start_busy", busy, 1);
        chk("start_ram_rd", ram_rd, 1);
        chk("start_ram_a", ram_a, b);
        while (beats < total && cyc < 2000) begin
            chk("no_early_done", done, 0);
            if (ram_rd) begin
                chk("rd_addr", ram_a, (b + issued % n) % D);
`ifdef DP_STREAM_READER_LOOP_EN
                loop = (issued < n * (passes - 1));
`endif
                issued++;
                chk("rd_count", issued <= total, 1);
                chk("outstanding", (issued - beats) <= 3, 1);
            end
            if (pstall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pdata);
            end
            ph = cyc % 6;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph == 1) || (ph == 4) || (ph == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid)
                chk("last", m_last, (beats % n) == (n - 1));
            if (m_valid && m_ready) begin
                if (mode == 0 && beats == 0)
                    chk("first_latency", cyc, 3);
                chk("data", m_data, mem[(b + beats % n) % D]);
                beats++;
                if (beats == stop_at)
                    return;
            end
            pstall = m_valid && !m_ready;
            pdata  = m_data;
            if (beats < total) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("complete", beats, total);
        if (mode == 0 && passes == 1)
            chk("last_beat_cycle", cyc, n + 2);
        @(negedge clk);
        m_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", m_valid, 0);
        chk("done_ram_rd", ram_rd, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        len = '0;
        m_ready = 1'b0;
`ifdef DP_STREAM_READER_LOOP_EN
        loop = 1'b0;
`endif
        for (int i = 0; i < D; i++)
            mem[i] = $urandom;
        for (int i = 0; i < 4; i++)
            mem[16 + i] = 32'hA0 + i;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_xfer(16'h010, 4, 0, 1, -1);
        run_xfer(16'h3FE, 4, 0, 1, -1);
        run_xfer(16'h100, 8, 1, 1, -1);
        run_xfer(16'h055, 0, 0, 1, -1);

        run_xfer(16'h200, 8, 0, 1, 3);
        rst = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", m_valid, 0);
        run_xfer(16'h020, 2, 0, 1, -1);

        for (int t = 0; t < 6; t++)
            run_xfer($urandom_range(0, D - 1), $urandom_range(1, 12), 2, 1, -1);

`ifdef DP_STREAM_READER_LOOP_EN
        run_xfer(16'h030, 3, 0, 3, -1);
        run_xfer(16'h3FF, 1, 2, 4, -1);
        run_xfer(16'h123, 5, 2, 2, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
